// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding and
// the width of the latency down-counter.
package mem_resp_pkg;

    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        COOL = 2'd3
    } mem_resp_state_t;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port DEPTH x DATA_WIDTH storage with synchronous write and synchronous read.
// Contents are not reset.
module mem_resp_ram #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request in IDLE, answers with a
// one-cycle ready pulse LATENCY cycles later, then spends one COOL cycle.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mem_valid_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_adr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    output logic                  mem_ready_o,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    output logic                  mem_err_o,
    output logic                  busy_o
);

    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY must lie in 1..15");
    end
    if (longint'(DEPTH) > (64'd1 << ADDR_WIDTH) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_responder: DEPTH must be a power of two no larger than 2**ADDR_WIDTH");
    end

    mem_resp_state_t        state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  adr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   ready_q, err_q;
    logic [DATA_WIDTH-1:0]  rd_q;

    logic                   req_we, req_ok, entering_resp, accept;
    logic [ADDR_WIDTH-1:0]  req_adr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   ram_we, ram_re;
    logic [DATA_WIDTH-1:0]  ram_rdata, resp_rdata;

    // In IDLE the live inputs are the request (LATENCY=1 enters RESP on the
    // accept edge); afterwards only the latched copy is used.
    always_comb begin
        req_we    = we_q;
        req_adr   = adr_q;
        req_wdata = wdata_q;
        if (state_q == IDLE) begin
            req_we    = mem_we_i;
            req_adr   = mem_adr_i;
            req_wdata = mem_wdata_i;
        end
    end

    assign req_ok        = {1'b0, req_adr} < DEPTH_LIM;
    assign accept        = (state_q == IDLE) && mem_valid_i;
    assign entering_resp = (state_d == RESP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    cnt_d   = LAT_CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LAT_CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Storage is touched only on the edge entering RESP, and never while reset
    // is asserted, so an abandoned write cannot commit.
    assign ram_we = rst_ni && entering_resp && req_we && req_ok;
    assign ram_re = rst_ni && entering_resp && !req_we && req_ok;

    mem_resp_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk_i (clk_i),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (req_adr[IDX_W-1:0]),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= entering_resp;
            err_q   <= entering_resp && !req_ok;
            if (accept) begin
                we_q <= mem_we_i;
            end
            if (state_q == RESP && !we_q) begin
                rd_q <= resp_rdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            adr_q   <= mem_adr_i;
            wdata_q <= mem_wdata_i;
        end
    end

    // Read data comes straight from the RAM during RESP and is held afterwards.
    assign resp_rdata  = err_q ? '0 : ram_rdata;
    assign mem_rdata_o = (state_q == RESP && !we_q) ? resp_rdata : rd_q;
    assign mem_ready_o = ready_q;
    assign mem_err_o   = err_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning memory-side word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data word width.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning number of stored words; power of two, at most 2**ADDR_WIDTH.
REQ-004 SHALL have parameter LATENCY, default 4, meaning cycles from request accept to mem_ready_o; legal range 1..15.
REQ-005 SHALL have port clk_i, input, 1 bit, clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit, reset; asynchronous, active-low.
REQ-007 SHALL have port mem_valid_i, input, 1 bit, request valid from the cache initiator.
REQ-008 SHALL have port mem_we_i, input, 1 bit, 1 = write, 0 = read.
REQ-009 SHALL have port mem_adr_i, input, ADDR_WIDTH bits, word address.
REQ-010 SHALL have port mem_wdata_i, input, DATA_WIDTH bits, write data.
REQ-011 SHALL have port mem_ready_o, output, 1 bit, one-cycle completion pulse.
REQ-012 SHALL have port mem_rdata_o, output, DATA_WIDTH bits, read data, valid while mem_ready_o is high.
REQ-013 SHALL have port mem_err_o, output, 1 bit, out-of-range flag, valid while mem_ready_o is high.
REQ-014 SHALL have port busy_o, output, 1 bit, high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, WAIT, RESP and COOL.
REQ-016 In IDLE, mem_valid_i=1 at a rising edge SHALL accept the request: mem_we_i, mem_adr_i and mem_wdata_i are latched, the down-counter is loaded with LATENCY-1, and the next state is WAIT (or RESP when LATENCY=1).
REQ-017 Request inputs SHALL be ignored after accept; changes to them while busy SHALL have no effect.
REQ-018 In WAIT, the counter SHALL decrement each cycle, and the state SHALL move to RESP when the counter reaches 1.
REQ-019 mem_ready_o SHALL be registered and SHALL be high for exactly the one cycle in RESP, which is exactly LATENCY cycles after the accept edge.
REQ-020 A read SHALL drive mem_rdata_o with the stored word in the RESP cycle; mem_rdata_o SHALL hold that value until the next read completes.
REQ-021 A write SHALL commit the latched data to storage at the edge entering RESP; mem_rdata_o SHALL be unchanged by the write.
REQ-022 An address is out of range when latched adr >= DEPTH; mem_err_o SHALL then be 1 in RESP, a write SHALL be dropped, and a read SHALL return all zeros.
REQ-023 The storage index SHALL be adr[$clog2(DEPTH)-1:0]; no wrap-around SHALL occur for out-of-range addresses.
REQ-024 RESP SHALL go to COOL, and COOL SHALL go to IDLE unconditionally; mem_valid_i in COOL SHALL be ignored, because the initiator drops valid in the cycle after ready.
REQ-025 Back-to-back requests SHALL be accepted: mem_valid_i held high into IDLE SHALL be accepted there, giving a minimum request period of LATENCY+2 cycles.
REQ-026 mem_valid_i deasserted while busy SHALL NOT abort the transaction; the response SHALL still be issued.
REQ-027 A read that follows a write to the same address SHALL return the newly written data.

Reset
REQ-028 Reset assertion SHALL drive state to IDLE, counter to 0, mem_ready_o to 0, mem_err_o to 0, mem_rdata_o to 0 and busy_o to 0, immediately and without a clock.
REQ-029 Reset mid-transaction SHALL abandon the transaction without issuing a ready pulse; a pending write SHALL NOT commit.
REQ-030 Storage contents SHALL NOT be reset and are undefined until written.

Structure
REQ-031 Package mem_resp_pkg SHALL hold the state enum mem_resp_state_t and the counter width constant LAT_CNT_W = 4.
REQ-032 Storage SHALL be the sub-module mem_resp_ram: single-port, synchronous write and read, DEPTH x DATA_WIDTH; the control FSM SHALL stay in mem_responder.
REQ-033 A parameter check SHALL error at elaboration for LATENCY outside 1..15 or DEPTH > 2**ADDR_WIDTH.

Verification
REQ-034 Write then read: write 0x0010 <= 0xDEADBEEF, then read 0x0010 -> mem_ready_o exactly 4 cycles after each accept, read returns 0xDEADBEEF, mem_err_o = 0.
REQ-035 Back-to-back: mem_valid_i held high for writes 0x0020 <= 0xBEEFDEAD and then 0x0021 <= 0x12345678 -> two ready pulses 6 cycles apart, and both locations read back correctly.
REQ-036 Out of range: write 0x0400 <= 0xCAFEF00D, then read 0x0400 -> mem_err_o = 1 with each ready, rdata 0x00000000, and location 0x0000 unchanged.
REQ-037 Abort: reset pulsed 2 cycles after accepting write 0x0030 <= 0xA5A5A5A5 -> no ready pulse, busy_o = 0 immediately, and a later read of 0x0030 does not return 0xA5A5A5A5 (pre-initialise it to 0).
REQ-038 LATENCY=1 build: read 0x0010 -> ready on the first cycle after accept, and a new request on the cycle after ready is ignored (COOL).
REQ-039 Input churn: mem_adr_i and mem_wdata_i toggled every cycle while busy -> only the values latched at accept take effect.
